// File: rtl/sdram_arb_pkg.sv
// Shared field positions and FSM encoding for the SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int unsigned CMD_WRITE_BIT = 35;
  localparam int unsigned CMD_BEATS_MSB = 34;
  localparam int unsigned CMD_BEATS_LSB = 32;
  localparam int unsigned DATA_LAST_BIT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order queue of 1-bit master ids for outstanding read commands.
module sdram_arb_tag_fifo #(
  parameter int TAG_DEPTH = 4,
  parameter int TAG_AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            din,
  input  logic            pop,
  output logic            head,
  output logic            full,
  output logic            empty,
  output logic [TAG_AW:0] count
);

  logic [TAG_DEPTH-1:0] mem;
  logic [TAG_AW-1:0]    wptr;
  logic [TAG_AW-1:0]    rptr;
  logic                 wr;
  logic                 rd;

  assign full  = (count == (TAG_AW+1)'(TAG_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  // Pointers are TAG_AW bits wide, so they wrap modulo TAG_DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (rd)
        rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-master arbiter in front of the SDRAM controller CFIFO/WFIFO/RFIFO ports.
// Define SDRAM_ARB_FIXED_PRIO_EN to make M0 win every tie instead of round-robin.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 4,
  parameter int TAG_AW    = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        M0_CMD_VALID,
  input  logic [35:0] M0_CMD_DATA,
  output logic        M0_CMD_READY,
  input  logic        M0_WD_VALID,
  input  logic [32:0] M0_WD_DATA,
  output logic        M0_WD_READY,
  output logic        M0_RD_VALID,
  output logic [32:0] M0_RD_DATA,
  input  logic        M0_RD_READY,
  input  logic        M1_CMD_VALID,
  input  logic [35:0] M1_CMD_DATA,
  output logic        M1_CMD_READY,
  input  logic        M1_WD_VALID,
  input  logic [32:0] M1_WD_DATA,
  output logic        M1_WD_READY,
  output logic        M1_RD_VALID,
  output logic [32:0] M1_RD_DATA,
  input  logic        M1_RD_READY,
  output logic        CFIFO_WEN,
  output logic [35:0] CFIFO_WDATA,
  input  logic        CFIFO_WFULL,
  output logic        WFIFO_WEN,
  output logic [32:0] WFIFO_WDATA,
  input  logic        WFIFO_WFULL,
  output logic        RFIFO_REN,
  input  logic [32:0] RFIFO_RDATA,
  input  logic        RFIFO_REMPTY,
  output logic        ERR
);

  arb_state_t      state;
  logic            owner;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic            last_grant;
`endif
  logic            active;
  logic            tag_room;
  logic [1:0]      elig;
  logic            cand;
  logic [35:0]     cand_cmd;
  logic            cmd_hs;
  logic            wd_phase;
  logic            owner_wd_valid;
  logic [32:0]     owner_wd;
  logic            rd_avail;
  logic            rd_route;
  logic            orphan;
  logic            rd_hs;
  logic            tag_push;
  logic            tag_pop;
  logic            tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic [TAG_AW:0] tag_count;

  // All handshake outputs are held low while reset is asserted.
  assign active   = ~HRESET;
  assign tag_room = (tag_count < (TAG_AW+1)'(TAG_DEPTH));

  // A read blocked by a full tag queue must not stall a write from the other master.
  assign elig[0] = M0_CMD_VALID & (M0_CMD_DATA[CMD_WRITE_BIT] | tag_room);
  assign elig[1] = M1_CMD_VALID & (M1_CMD_DATA[CMD_WRITE_BIT] | tag_room);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign cand = ~elig[0];
`else
  assign cand = (elig == 2'b11) ? ~last_grant : elig[1];
`endif

  assign cand_cmd     = cand ? M1_CMD_DATA : M0_CMD_DATA;
  assign cmd_hs       = active & (state == IDLE) & (|elig) & ~CFIFO_WFULL;
  assign M0_CMD_READY = cmd_hs & ~cand;
  assign M1_CMD_READY = cmd_hs & cand;
  assign CFIFO_WEN    = cmd_hs;
  assign CFIFO_WDATA  = cand_cmd;

  assign wd_phase       = active & (state == WDATA);
  assign owner_wd_valid = owner ? M1_WD_VALID : M0_WD_VALID;
  assign owner_wd       = owner ? M1_WD_DATA : M0_WD_DATA;
  assign M0_WD_READY    = wd_phase & ~owner & ~WFIFO_WFULL;
  assign M1_WD_READY    = wd_phase & owner & ~WFIFO_WFULL;
  assign WFIFO_WEN      = wd_phase & owner_wd_valid & ~WFIFO_WFULL;
  assign WFIFO_WDATA    = owner_wd;

  assign rd_avail    = active & ~RFIFO_REMPTY;
  assign rd_route    = rd_avail & ~tag_empty;
  assign orphan      = rd_avail & tag_empty;
  assign M0_RD_VALID = rd_route & ~tag_head;
  assign M1_RD_VALID = rd_route & tag_head;
  assign M0_RD_DATA  = RFIFO_RDATA;
  assign M1_RD_DATA  = RFIFO_RDATA;
  assign rd_hs       = (M0_RD_VALID & M0_RD_READY) | (M1_RD_VALID & M1_RD_READY);
  assign RFIFO_REN   = rd_hs | orphan;

  assign tag_push = cmd_hs & ~cand_cmd[CMD_WRITE_BIT] & ~tag_full;
  assign tag_pop  = rd_hs & RFIFO_RDATA[DATA_LAST_BIT];

  sdram_arb_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH),
    .TAG_AW    (TAG_AW)
  ) u_tags (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (tag_push),
    .din   (cand),
    .pop   (tag_pop),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
      owner <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      ERR   <= 1'b0;
    end else begin
      if (orphan)
        ERR <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_grant <= cand;
`endif
            if (cand_cmd[CMD_WRITE_BIT]) begin
              owner <= cand;
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (WFIFO_WEN && owner_wd[DATA_LAST_BIT])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Two-requester arbiter in the HCLK domain in front of the SDRAM controller's writer-side FIFO ports: command FIFO CFIFO, write-data FIFO WFIFO, and the read side of read-data FIFO RFIFO.
- Multiplexes commands and write beats from masters M0/M1 (e.g. AHB bridge, DMA) and routes returned read beats back to the issuing master via an in-order tag queue.
- Guarantees that write beats for one command are never interleaved with another master's beats.

Parameters:
TAG_DEPTH, 4, max outstanding read commands; power of 2, 2..16
TAG_AW, 2, log2(TAG_DEPTH)

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous active-high reset
Mx_CMD_VALID  in  1  master x (x=0,1) command valid
Mx_CMD_DATA  in  36  command: [35]=write, [34:32]=beats-1, [31:0]=address
Mx_CMD_READY  out  1  command accepted when VALID&READY
Mx_WD_VALID  in  1  write beat valid
Mx_WD_DATA  in  33  [32]=last beat, [31:0]=data
Mx_WD_READY  out  1  write beat accepted
Mx_RD_VALID  out  1  read beat to master x
Mx_RD_DATA  out  33  [32]=last, [31:0]=data
Mx_RD_READY  in  1  master x accepts read beat
CFIFO_WEN  out  1  push command
CFIFO_WDATA  out  36  command passed unchanged
CFIFO_WFULL  in  1  command FIFO full
WFIFO_WEN  out  1  push write beat
WFIFO_WDATA  out  33  beat passed unchanged
WFIFO_WFULL  in  1  write FIFO full
RFIFO_REN  out  1  pop read beat
RFIFO_RDATA  in  33  read beat, valid while !RFIFO_REMPTY (show-ahead)
RFIFO_REMPTY  in  1  read FIFO empty
ERR  out  1  sticky: read beat arrived with tag queue empty

Behaviour:
- Reset: all READY/VALID/WEN/REN outputs 0, FSM=IDLE, last-grant=M1 (M0 wins first tie), tag queue empty, ERR=0. Reset mid-burst drops state; outstanding tags are lost.
- FSM states: IDLE, WDATA.
- IDLE, candidate selection:
  - Candidate = requesting master. If both request, the master not granted last wins (round-robin).
  - Mx_CMD_READY=1 for the candidate only, iff !CFIFO_WFULL and (write or tag count<TAG_DEPTH).
  - Combinational pass-through, zero latency: CFIFO_WEN = handshake, CFIFO_WDATA = candidate CMD_DATA.
- IDLE, on handshake:
  - Update last-grant.
  - Write command: owner := candidate, go to WDATA.
  - Read command: push tag (master id) into the queue, stay IDLE. Back-to-back read accepts on consecutive cycles are allowed.
- WDATA:
  - Owner Mx_WD_READY = !WFIFO_WFULL. WFIFO_WEN = owner WD_VALID & !WFIFO_WFULL.
  - All CMD_READY = 0. Non-owner WD_READY = 0.
  - Beat with [32]=1 accepted: return to IDLE next cycle. No beat counting; the last flag is authoritative.
- Read return:
  - If queue non-empty and !RFIFO_REMPTY: head-tag master gets Mx_RD_VALID=1, RD_DATA=RFIFO_RDATA. The other master's RD_VALID=0.
  - RFIFO_REN = RD_VALID & RD_READY. On a popped beat with [32]=1, pop the tag.
  - If the queue is empty and !RFIFO_REMPTY: pop the beat (discard) and set ERR. ERR clears only on reset.
- Tag push and pop in the same cycle: count unchanged, both take effect.
- Tag pointers wrap modulo TAG_DEPTH.
- Read return runs concurrently with IDLE/WDATA; it is independent of the grant FSM.
- Full: CFIFO_WFULL blocks all commands; tag full blocks reads only; writes still proceed.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: M0 always wins when both request in IDLE; last-grant is unused.
- Undefined: round-robin as above.
- Write-burst atomicity and read routing are identical in both builds.

Decomposition:
- Shared package sdram_arb_pkg:
  - Command field constants: CMD_WRITE_BIT=35, CMD_BEATS_MSB=34, CMD_BEATS_LSB=32.
  - Beat field constant DATA_LAST_BIT=32.
  - FSM state encoding: IDLE=0, WDATA=1.
- Sub-module sdram_arb_tag_fifo: single-clock 1-bit-wide FIFO, depth TAG_DEPTH, with push, pop, head, full, empty and count outputs.

Test Plan:
1. Read M0 (cmd 0x0_0000_1000, beats-1=0), RFIFO returns 0x1_DEADBEEF -> M0_RD_VALID with data 0x1_DEADBEEF; M1_RD_VALID stays 0; tag queue returns to empty.
2. M0 and M1 request reads in the same cycle -> M0 granted first, M1 next cycle. Returned beats 0x1_AAAA0000 then 0x1_BBBB0000 reach M0 then M1 respectively.
3. M1 issues a 4-beat write while M0 holds CMD_VALID -> M0_CMD_READY=0 until M1's 4th beat (last=1) is accepted. WFIFO receives exactly 4 consecutive M1 beats; M0 is granted next cycle.
4. Five M0 reads with TAG_DEPTH=4 and no returns -> 5th read stalled (READY=0). A concurrent M1 write command is accepted; the 5th read is accepted the cycle after the first tag pops.
5. CFIFO_WFULL=1 with both masters valid -> no CMD_READY, no CFIFO_WEN. Deassert -> round-robin grant resumes. WFIFO_WFULL mid-burst stalls WD_READY without losing beats.
6. RFIFO non-empty with queue empty -> beat popped, ERR=1 and sticky. Reset asserted mid-write -> all outputs 0, FSM=IDLE, ERR=0. With SDRAM_ARB_FIXED_PRIO_EN, repeated ties always grant M0.
